// File: rtl/sprite_blit_controller_pkg.sv
// Shared definitions for the sprite blitter: colour width, screen geometry,
// transparency key and the blit FSM encoding.
package sprite_blit_controller_pkg;

    localparam int COLOR_W       = 3;
    localparam int SCREEN_XW_DEF = 8;
    localparam int SCREEN_YW_DEF = 7;
    localparam int SCREEN_W_DEF  = 160;
    localparam int SCREEN_H_DEF  = 120;

    localparam logic [COLOR_W-1:0] TRANSP_COLOR_DEF = 3'b000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } blit_state_t;

    // A pixel is skipped only when keying is enabled and the colour matches the key.
    function automatic logic is_transparent(
        input logic               en,
        input logic [COLOR_W-1:0] color,
        input logic [COLOR_W-1:0] key
    );
        return en && (color == key);
    endfunction

endpackage

// File: rtl/sprite_blit_controller_scan_counter.sv
// Raster-order sprite coordinate counter with clear, enable and a flag that
// marks the last pixel; also usable for background blits.
module sprite_scan_counter #(
    parameter int WIDTH_X  = 4,
    parameter int WIDTH_Y  = 3,
    parameter int SPRITE_W = 10,
    parameter int SPRITE_H = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear,
    input  logic               enable,
    output logic [WIDTH_X-1:0] sx,
    output logic [WIDTH_Y-1:0] sy,
    output logic               last
);

    localparam logic [WIDTH_X-1:0] LAST_X = WIDTH_X'(SPRITE_W - 1);
    localparam logic [WIDTH_Y-1:0] LAST_Y = WIDTH_Y'(SPRITE_H - 1);

    // The count wraps to (0,0) after the last pixel so a new scan can follow directly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sx <= '0;
            sy <= '0;
        end else if (clear) begin
            sx <= '0;
            sy <= '0;
        end else if (enable) begin
            if (sx == LAST_X) begin
                sx <= '0;
                sy <= (sy == LAST_Y) ? '0 : sy + 1'b1;
            end else begin
                sx <= sx + 1'b1;
            end
        end
    end

    assign last = (sx == LAST_X) && (sy == LAST_Y);

endmodule

// File: rtl/sprite_blit_controller.sv
// Sequences one sprite draw: scans the sprite RAM in raster order, follows its
// one-cycle read latency and emits clipped, colour-keyed VGA pixel writes.
module sprite_blit_controller
    import sprite_blit_controller_pkg::*;
#(
    parameter int                 WIDTH_X      = 4,
    parameter int                 WIDTH_Y      = 3,
    parameter int                 SPRITE_W     = 10,
    parameter int                 SPRITE_H     = 6,
    parameter int                 SCREEN_XW    = SCREEN_XW_DEF,
    parameter int                 SCREEN_YW    = SCREEN_YW_DEF,
    parameter int                 SCREEN_W     = SCREEN_W_DEF,
    parameter int                 SCREEN_H     = SCREEN_H_DEF,
    parameter bit                 TRANSP_EN    = 1'b1,
    parameter logic [COLOR_W-1:0] TRANSP_COLOR = TRANSP_COLOR_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [SCREEN_XW-1:0] pos_x,
    input  logic [SCREEN_YW-1:0] pos_y,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH_X-1:0]   rom_x,
    output logic [WIDTH_Y-1:0]   rom_y,
    input  logic [COLOR_W-1:0]   rom_color,
    output logic [SCREEN_XW-1:0] vga_x,
    output logic [SCREEN_YW-1:0] vga_y,
    output logic [COLOR_W-1:0]   vga_color,
    output logic                 vga_plot
);

    localparam logic [SCREEN_XW:0] X_LIMIT = (SCREEN_XW + 1)'(SCREEN_W);
    localparam logic [SCREEN_YW:0] Y_LIMIT = (SCREEN_YW + 1)'(SCREEN_H);

    blit_state_t state, next_state;

    logic                 drain_second;
    logic                 accept;
    logic                 cnt_clear;
    logic                 cnt_en;
    logic                 scan_last;
    logic [WIDTH_X-1:0]   sx;
    logic [WIDTH_Y-1:0]   sy;
    logic [SCREEN_XW-1:0] pos_x_q;
    logic [SCREEN_YW-1:0] pos_y_q;

    logic                 s1_valid;
    logic [WIDTH_X-1:0]   s1_sx;
    logic [WIDTH_Y-1:0]   s1_sy;
    logic [SCREEN_XW:0]   scr_x;
    logic [SCREEN_YW:0]   scr_y;
    logic                 on_screen;

    sprite_scan_counter #(
        .WIDTH_X  (WIDTH_X),
        .WIDTH_Y  (WIDTH_Y),
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_scan (
        .clk    (clk),
        .resetn (resetn),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .sx     (sx),
        .sy     (sy),
        .last   (scan_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            drain_second <= 1'b0;
            done         <= 1'b0;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
        end else begin
            state        <= next_state;
            drain_second <= (state == DRAIN) ? ~drain_second : 1'b0;
            done         <= (state == DRAIN) && drain_second;
            if (accept) begin
                pos_x_q <= pos_x;
                pos_y_q <= pos_y;
            end
        end
    end

    // Start is only honoured from IDLE, so a held start re-triggers exactly on the done cycle.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            IDLE: begin
                cnt_clear = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = SCAN;
                end
            end
            SCAN: begin
                cnt_en = 1'b1;
                if (scan_last) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_second) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign rom_x = (state == SCAN) ? sx : '0;
    assign rom_y = (state == SCAN) ? sy : '0;

    // Stage 1 lines the sprite coordinate up with the RAM data returning a cycle later.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_sx    <= '0;
            s1_sy    <= '0;
        end else begin
            s1_valid <= (state == SCAN);
            s1_sx    <= sx;
            s1_sy    <= sy;
        end
    end

    assign scr_x = {1'b0, pos_x_q} + {{(SCREEN_XW + 1 - WIDTH_X){1'b0}}, s1_sx};
    assign scr_y = {1'b0, pos_y_q} + {{(SCREEN_YW + 1 - WIDTH_Y){1'b0}}, s1_sy};
    assign on_screen = (scr_x < X_LIMIT) && (scr_y < Y_LIMIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= '0;
            vga_plot  <= 1'b0;
        end else begin
            vga_x     <= scr_x[SCREEN_XW-1:0];
            vga_y     <= scr_y[SCREEN_YW-1:0];
            vga_color <= rom_color;
            vga_plot  <= s1_valid && on_screen
                         && !is_transparent(TRANSP_EN, rom_color, TRANSP_COLOR);
        end
    end

endmodule

// File: tb/tb_sprite_blit_controller.sv
// Scoreboard bench: two blitters (colour keying on / off) share stimulus and
// a 1-cycle-latency sprite RAM model; every cycle is checked against a queue.
module tb_sprite_blit_controller;

    localparam int SW   = 10;
    localparam int SH   = 6;
    localparam int NPIX = SW * SH;

    typedef struct {
        bit         busy;
        bit         done;
        bit         plot;
        int         x;
        int         y;
        logic [2:0] color;
    } rec_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] pos_x;
    logic [6:0] pos_y;
    logic [2:0] rom_color;

    logic       busy0, done0, plot0, busy1, done1, plot1;
    logic [3:0] rom_x0, rom_x1;
    logic [2:0] rom_y0, rom_y1;
    logic [7:0] vga_x0, vga_x1;
    logic [6:0] vga_y0, vga_y1;
    logic [2:0] color0, color1;

    logic [2:0] mem [SH][SW];
    rec_t       q0[$];
    rec_t       q1[$];
    int         checks = 0;
    int         errors = 0;
    int         plots0 = 0;
    int         plots1 = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_color <= mem[rom_y0][rom_x0];

    sprite_blit_controller #(.TRANSP_EN(1'b1)) dut_key (
        .clk(clk), .resetn(resetn), .start(start), .pos_x(pos_x), .pos_y(pos_y),
        .busy(busy0), .done(done0), .rom_x(rom_x0), .rom_y(rom_y0),
        .rom_color(rom_color), .vga_x(vga_x0), .vga_y(vga_y0),
        .vga_color(color0), .vga_plot(plot0)
    );

    sprite_blit_controller #(.TRANSP_EN(1'b0)) dut_nokey (
        .clk(clk), .resetn(resetn), .start(start), .pos_x(pos_x), .pos_y(pos_y),
        .busy(busy1), .done(done1), .rom_x(rom_x1), .rom_y(rom_y1),
        .rom_color(rom_color), .vga_x(vga_x1), .vga_y(vga_y1),
        .vga_color(color1), .vga_plot(plot1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pattern 0: solid 3'b101. Pattern 1: varied non-zero colours with a 4x3 transparent block.
    task automatic set_pattern(input int kind);
        for (int y = 0; y < SH; y++) begin
            for (int x = 0; x < SW; x++) begin
                if (kind == 0)
                    mem[y][x] = 3'b101;
                else if (x < 4 && y < 3)
                    mem[y][x] = 3'b000;
                else
                    mem[y][x] = 3'((x * 3 + y) % 7 + 1);
            end
        end
    endtask

    task automatic push_idle(input int n);
        rec_t r;
        r = '{busy: 1'b0, done: 1'b0, plot: 1'b0, x: 0, y: 0, color: 3'b000};
        for (int i = 0; i < n; i++) begin
            q0.push_back(r);
            q1.push_back(r);
        end
    endtask

    // Expected per-cycle view of one draw, cycles 1..N+3 after the accepting edge.
    task automatic push_draw(input int px, input int py);
        rec_t r0, r1;
        int   idx, sx, sy;
        bit   onscr;
        for (int c = 1; c <= NPIX + 3; c++) begin
            r0 = '{busy: (c <= NPIX + 2), done: (c == NPIX + 3), plot: 1'b0,
                   x: 0, y: 0, color: 3'b000};
            r1 = r0;
            if (c >= 3 && c <= NPIX + 2) begin
                idx      = c - 3;
                sx       = idx % SW;
                sy       = idx / SW;
                r0.x     = px + sx;
                r0.y     = py + sy;
                r0.color = mem[sy][sx];
                onscr    = (r0.x < 160) && (r0.y < 120);
                r0.plot  = onscr && (r0.color != 3'b000);
                r1.x     = r0.x;
                r1.y     = r0.y;
                r1.color = r0.color;
                r1.plot  = onscr;
            end
            q0.push_back(r0);
            q1.push_back(r1);
        end
    endtask

    task automatic applyStimulus(input int px, input int py);
        pos_x  = 8'(px);
        pos_y  = 7'(py);
        start  = 1'b1;
        plots0 = 0;
        plots1 = 0;
        push_draw(px, py);
    endtask

    task automatic checkOutput();
        rec_t e0, e1;
        if (q0.size() == 0 || q1.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        check("busy_key", busy0, e0.busy);
        check("done_key", done0, e0.done);
        check("plot_key", plot0, e0.plot);
        if (e0.plot) begin
            check("x_key", vga_x0, e0.x);
            check("y_key", vga_y0, e0.y);
            check("color_key", color0, e0.color);
        end
        check("busy_nokey", busy1, e1.busy);
        check("done_nokey", done1, e1.done);
        check("plot_nokey", plot1, e1.plot);
        if (e1.plot) begin
            check("x_nokey", vga_x1, e1.x);
            check("y_nokey", vga_y1, e1.y);
            check("color_nokey", color1, e1.color);
        end
        if (plot0) plots0++;
        if (plot1) plots1++;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            checkOutput();
        end
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        pos_x  = '0;
        pos_y  = '0;
        set_pattern(0);
        #12;
        check("reset_busy", busy0, 0);
        check("reset_done", done0, 0);
        check("reset_plot", plot0, 0);
        check("reset_rom_x", rom_x0, 0);
        check("reset_rom_y", rom_y1, 0);
        check("reset_vga_x", vga_x0, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        push_idle(2);
        run_cycles(2);

        $display("[TB] basic draw at (20,30)");
        applyStimulus(20, 30);
        run_cycles(1);
        start = 1'b0;
        run_cycles(NPIX + 2);
        check("basic_count_key", plots0, 60);
        check("basic_count_nokey", plots1, 60);

        $display("[TB] transparency pattern");
        set_pattern(1);
        applyStimulus(5, 5);
        run_cycles(1);
        start = 1'b0;
        run_cycles(NPIX + 2);
        check("transp_count_key", plots0, 48);
        check("transp_count_nokey", plots1, 60);

        $display("[TB] clip at (155,117)");
        set_pattern(0);
        applyStimulus(155, 117);
        run_cycles(1);
        start = 1'b0;
        run_cycles(NPIX + 2);
        check("clip_count_key", plots0, 15);
        check("clip_count_nokey", plots1, 15);

        $display("[TB] start held through draw");
        set_pattern(1);
        applyStimulus(40, 50);
        run_cycles(1);
        pos_x = 8'd1;
        pos_y = 7'd2;
        run_cycles(NPIX + 2);
        push_draw(1, 2);
        check("held_first_count_key", plots0, 48);
        plots0 = 0;
        plots1 = 0;
        run_cycles(1);
        start = 1'b0;
        run_cycles(NPIX + 2);
        check("held_second_count_key", plots0, 48);
        check("held_second_count_nokey", plots1, 60);

        $display("[TB] back-to-back pulses");
        push_idle(1);
        run_cycles(1);
        set_pattern(0);
        applyStimulus(10, 10);
        run_cycles(1);
        start = 1'b0;
        run_cycles(NPIX + 2);
        check("b2b_first_count", plots0, 60);
        applyStimulus(0, 0);
        run_cycles(1);
        start = 1'b0;
        run_cycles(NPIX + 2);
        check("b2b_second_count", plots0, 60);

        $display("[TB] reset mid-scan");
        applyStimulus(7, 7);
        run_cycles(1);
        start = 1'b0;
        run_cycles(10);
        resetn = 1'b0;
        #1;
        check("midreset_busy", busy0, 0);
        check("midreset_done", done0, 0);
        check("midreset_plot", plot0, 0);
        check("midreset_plot_nokey", plot1, 0);
        check("midreset_rom_x", rom_x0, 0);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        push_idle(2);
        run_cycles(2);
        applyStimulus(0, 0);
        run_cycles(1);
        start = 1'b0;
        run_cycles(NPIX + 2);
        check("after_reset_count_key", plots0, 60);
        check("after_reset_count_nokey", plots1, 60);

        push_idle(2);
        run_cycles(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
